muldiv_issue_ctrl: RTL

- Sequences the shared iterative multiply/divide unit in the execute stage for RV32M instructions.
- Accepts one operation per instruction from the ID/EX register and issues it to the unit.
- Stalls the front of the pipeline while the unit is busy, then presents the result for one pipeline-advance cycle.
- Resolves divide-by-zero and signed overflow locally without using the unit. Handles flush and debug/memory hold, and includes a wait-state watchdog.

---
 rtl/muldiv_issue_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: issue/sequencing controller for the shared iterative
// RV32M multiply/divide unit in the execute stage. It accepts one op from
// ID/EX, resolves divide-by-zero and signed overflow locally, otherwise
// issues the op to the unit, stalls the front end while waiting, and presents
// the result for one pipeline-advance cycle. A wait-state watchdog aborts
// operations whose done pulse never arrives.
//
// Optional build macro: MULDIV_OPCACHE_EN adds a one-entry result cache that
// short-circuits an exact op/a/b repeat straight to DONE.

module muldiv_issue_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic            hold,
    input  logic            flush,
    input  logic            req_valid,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [4:0]      req_rd,
    output logic            stall,
    output logic            res_valid,
    output logic [XLEN-1:0] res_data,
    output logic [4:0]      res_rd,
    output logic            err,
    output logic            unit_start,
    output logic [2:0]      unit_op,
    output logic [XLEN-1:0] unit_a,
    output logic [XLEN-1:0] unit_b,
    input  logic            unit_done,
    input  logic [XLEN-1:0] unit_res
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_t;

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    state_t            next_state;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   res_q;
    logic [CW-1:0]     cnt;
    logic              err_q;
    logic              pending_q;

    logic              accept;
    logic              is_div;
    logic              b_zero;
    logic              sgn_ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;
    logic              timeout_fire;
    logic              cache_hit;
    logic [XLEN-1:0]   cache_res;

    // Decode the incoming request: acceptance and locally resolvable divides.
    always_comb begin
        accept      = (state == IDLE) && req_valid && !hold && !flush;
        is_div      = req_op[2];
        b_zero      = (req_b == '0);
        sgn_ovf     = ((req_op == 3'd4) || (req_op == 3'd6)) &&
                      (req_a == MIN_NEG) && (req_b == '1);
        special     = is_div && (b_zero || sgn_ovf);
        special_res = '0;
        if (b_zero) begin
            special_res = req_op[1] ? req_a : '1;
        end else if (sgn_ovf) begin
            special_res = req_op[1] ? '0 : MIN_NEG;
        end
        timeout_fire = (state == WAIT) && !unit_done &&
                       (cnt == CW'(TIMEOUT - 1));
    end

    // Next-state and output logic; WAIT ignores hold so the unit's done
    // pulse and the watchdog are never lost while the pipeline is frozen.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        res_valid  = 1'b0;
        res_data   = '0;
        res_rd     = '0;
        unit_start = 1'b0;
        case (state)
            IDLE: begin
                stall = accept;
                if (accept) begin
                    if (special || cache_hit) begin
                        next_state = DONE;
                    end else begin
                        next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                stall      = 1'b1;
                unit_start = !hold;
                if (flush) begin
                    next_state = ABORT;
                end else if (!hold) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (flush || timeout_fire) begin
                    next_state = ABORT;
                end else if (unit_done) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                res_valid = !flush;
                res_data  = res_q;
                res_rd    = rd_q;
                if (flush || !hold) begin
                    next_state = IDLE;
                end
            end
            ABORT: begin
                stall = req_valid;
                if (!hold && (unit_done || !pending_q)) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, operand/result latches, watchdog counter and sticky error.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            res_q     <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state <= next_state;

            if (accept) begin
                op_q  <= req_op;
                a_q   <= req_a;
                b_q   <= req_b;
                rd_q  <= req_rd;
                res_q <= special ? special_res : cache_res;
            end

            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + CW'(1);
            end

            if (state == WAIT && next_state == DONE) begin
                res_q <= unit_res;
            end

            if (timeout_fire) begin
                err_q <= 1'b1;
                res_q <= '0;
            end

            if (unit_start) begin
                pending_q <= 1'b1;
            end else if (unit_done || timeout_fire) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign err     = err_q;
    assign unit_op = op_q;
    assign unit_a  = a_q;
    assign unit_b  = b_q;

`ifdef MULDIV_OPCACHE_EN
    logic            c_valid;
    logic [2:0]      c_op;
    logic [XLEN-1:0] c_a;
    logic [XLEN-1:0] c_b;
    logic [XLEN-1:0] c_res;

    // One-entry result cache: filled on every unit completion, dropped on
    // any abort (which also covers a watchdog error).
    always_ff @(posedge clk) begin
        if (Rst) begin
            c_valid <= 1'b0;
            c_op    <= '0;
            c_a     <= '0;
            c_b     <= '0;
            c_res   <= '0;
        end else if (next_state == ABORT && state != ABORT) begin
            c_valid <= 1'b0;
        end else if (state == WAIT && next_state == DONE) begin
            c_valid <= 1'b1;
            c_op    <= op_q;
            c_a     <= a_q;
            c_b     <= b_q;
            c_res   <= unit_res;
        end
    end

    assign cache_hit = c_valid && (c_op == req_op) &&
                       (c_a == req_a) && (c_b == req_b);
    assign cache_res = c_res;
`else
    assign cache_hit = 1'b0;
    assign cache_res = '0;
`endif

endmodule
